// File: rtl/ysyx_230000_axi_sram_slave_if.sv
// ysyx_230000_axi_sram_slave_if: AXI4 bus between an initiator and the SRAM responder
interface ysyx_230000_axi_sram_slave_if #(parameter int ID_W = 4);
  logic            awready;
  logic            awvalid;
  logic [31:0]     awaddr;
  logic [ID_W-1:0] awid;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            wready;
  logic            wvalid;
  logic [63:0]     wdata;
  logic [7:0]      wstrb;
  logic            wlast;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;
  logic            arready;
  logic            arvalid;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid;
  logic            rready;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;
  modport slave (
    output awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
    input  bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
  modport master (
    input  awready, wready, bvalid, bresp, bid, arready, rvalid, rdata, rresp, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst, wvalid, wdata, wstrb, wlast,
    output bready, arvalid, araddr, arid, arlen, arsize, arburst, rready
  );
endinterface

// File: rtl/ysyx_230000_axi_sram_slave.sv
// ysyx_230000_axi_sram_slave: AXI4 responder backed by one 64x128-bit SRAM macro
module ysyx_230000_axi_sram_slave #(
  parameter int ID_W = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_230000_axi_sram_slave_if.slave       io_slave,
  output logic [5:0]                        io_sram_addr,
  output logic                              io_sram_cen,
  output logic                              io_sram_wen,
  output logic [127:0]                      io_sram_wmask,
  output logic [127:0]                      io_sram_wdata,
  input  logic [127:0]                      io_sram_rdata
);
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_DATA} state_e;
  state_e          state_q;
  logic [9:0]      addr_q, addr_d;
  logic [ID_W-1:0] id_q;
  logic [7:0]      len_q, cnt_q;
  logic [1:0]      size_q, burst_q;
  logic            err_q, wr_gnt_last_q, first_q;
  logic            bvalid_q, rvalid_q, rlast_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [63:0]     rdata_q, rdata_d;
  logic            idle, bad, aw_gnt, ar_gnt, w_beat, w_last, mismatch;
  logic [63:0]     mask64, rd_half;
  logic            unused_hi;
  assign unused_hi = ^{io_slave.awaddr[31:10], io_slave.araddr[31:10]};
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign mask64[8*i +: 8] = {8{~io_slave.wstrb[i]}};
  end
  // Arbitration, beat address stepping and read-data selection
  always_comb begin
    idle     = state_q == IDLE && !reset;
    aw_gnt   = idle && (!io_slave.arvalid || (io_slave.awvalid && !wr_gnt_last_q));
    ar_gnt   = idle && !aw_gnt;
    bad      = burst_q[1];
    addr_d   = burst_q == 2'b01 ? addr_q + (10'd1 << size_q) : addr_q;
    w_beat   = state_q == WR_DATA && io_slave.wvalid;
    w_last   = cnt_q == len_q;
    mismatch = io_slave.wlast != w_last;
    rd_half  = addr_q[3] ? io_sram_rdata[127:64] : io_sram_rdata[63:0];
    rdata_d  = first_q ? (bad ? 64'd0 : rd_half) : rdata_q;
  end
  assign io_slave.awready = aw_gnt;
  assign io_slave.arready = ar_gnt;
  assign io_slave.wready  = state_q == WR_DATA;
  assign io_slave.bvalid  = bvalid_q;
  assign io_slave.bresp   = bresp_q;
  assign io_slave.bid     = id_q;
  assign io_slave.rvalid  = rvalid_q;
  assign io_slave.rdata   = rdata_d;
  assign io_slave.rresp   = rresp_q;
  assign io_slave.rlast   = rlast_q;
  assign io_slave.rid     = id_q;
  assign io_sram_addr  = addr_q[9:4];
  assign io_sram_cen   = !((w_beat || state_q == RD_REQ) && !bad);
  assign io_sram_wen   = !(w_beat && !bad);
  assign io_sram_wmask = w_beat && !bad ? (addr_q[3] ? {mask64, {64{1'b1}}} : {{64{1'b1}}, mask64}) : '1;
  assign io_sram_wdata = w_beat ? {2{io_slave.wdata}} : '0;
  // Transaction FSM with registered response outputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      id_q          <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      err_q         <= 1'b0;
      wr_gnt_last_q <= 1'b0;
      first_q       <= 1'b0;
      bvalid_q      <= 1'b0;
      rvalid_q      <= 1'b0;
      rlast_q       <= 1'b0;
      bresp_q       <= '0;
      rresp_q       <= '0;
      rdata_q       <= '0;
    end else begin
      first_q <= 1'b0;
      rdata_q <= rdata_d;
      case (state_q)
        IDLE:
          if (aw_gnt && io_slave.awvalid) begin
            addr_q        <= io_slave.awaddr[9:0];
            id_q          <= io_slave.awid;
            len_q         <= io_slave.awlen;
            size_q        <= io_slave.awsize[2] ? 2'd3 : io_slave.awsize[1:0];
            burst_q       <= io_slave.awburst;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            wr_gnt_last_q <= 1'b1;
            state_q       <= WR_DATA;
          end else if (ar_gnt && io_slave.arvalid) begin
            addr_q        <= io_slave.araddr[9:0];
            id_q          <= io_slave.arid;
            len_q         <= io_slave.arlen;
            size_q        <= io_slave.arsize[2] ? 2'd3 : io_slave.arsize[1:0];
            burst_q       <= io_slave.arburst;
            cnt_q         <= '0;
            wr_gnt_last_q <= 1'b0;
            state_q       <= RD_REQ;
          end
        WR_DATA:
          if (io_slave.wvalid) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_q + 8'd1;
            err_q  <= err_q || mismatch;
            if (w_last) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || mismatch || bad) ? 2'b10 : 2'b00;
              state_q  <= WR_RESP;
            end
          end
        WR_RESP:
          if (io_slave.bready) begin
            bvalid_q <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= IDLE;
          end
        RD_REQ: begin
          rvalid_q <= 1'b1;
          first_q  <= 1'b1;
          rlast_q  <= w_last;
          rresp_q  <= bad ? 2'b10 : 2'b00;
          state_q  <= RD_DATA;
        end
        RD_DATA:
          if (io_slave.rready) begin
            rvalid_q <= 1'b0;
            if (rlast_q) state_q <= IDLE;
            else begin
              addr_q  <= addr_d;
              cnt_q   <= cnt_q + 8'd1;
              state_q <= RD_REQ;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ysyx_230000_axi_sram_slave.sv
// tb_ysyx_230000_axi_sram_slave: randomized AXI traffic checked against a byte-array memory model
module tb_ysyx_230000_axi_sram_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ysyx_230000_axi_sram_slave_if #(.ID_W(4)) bus();
  logic [5:0]   sram_addr;
  logic         sram_cen, sram_wen;
  logic [127:0] sram_wmask, sram_wdata;
  logic [127:0] sram_rdata = '0;
  logic [127:0] sram [64] = '{default: '0};
  ysyx_230000_axi_sram_slave #(.ID_W(4)) dut (
    .clock(clk), .reset(rst), .io_slave(bus.slave),
    .io_sram_addr(sram_addr), .io_sram_cen(sram_cen), .io_sram_wen(sram_wen),
    .io_sram_wmask(sram_wmask), .io_sram_wdata(sram_wdata), .io_sram_rdata(sram_rdata)
  );
  // SRAM macro: masked write, one-cycle read latency
  always @(posedge clk)
    if (!sram_cen) begin
      if (!sram_wen) sram[sram_addr] <= (sram[sram_addr] & sram_wmask) | (sram_wdata & ~sram_wmask);
      else sram_rdata <= sram[sram_addr];
    end
  byte unsigned ref_mem [1024];
  logic [63:0]  wd [256];
  logic [7:0]   ws [256];
  int total = 0;
  int bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] nxt(input logic [9:0] a, input logic [2:0] size, input logic [1:0] burst);
    int step = 1 << (size > 3 ? 3 : size);
    return burst == 2'b01 ? 10'((int'(a) + step) % 1024) : a;
  endfunction
  function automatic logic [63:0] ref_rd(input logic [9:0] a);
    logic [63:0] r;
    int base = int'(a) / 8 * 8;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[base + i];
    return r;
  endfunction
  task automatic set_aw(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    bus.awaddr = a; bus.awlen = 8'(len); bus.awsize = size; bus.awburst = burst; bus.awid = id; bus.awvalid = 1'b1;
  endtask
  task automatic set_ar(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id);
    bus.araddr = a; bus.arlen = 8'(len); bus.arsize = size; bus.arburst = burst; bus.arid = id; bus.arvalid = 1'b1;
  endtask
  task automatic aw_wait();
    int n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake", bus.awready, 1);
    @(posedge clk); #1 bus.awvalid = 1'b0;
  endtask
  task automatic ar_wait();
    int n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake", bus.arready, 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
  endtask
  task automatic w_data(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id, input int wlast_at);
    logic [9:0] ba = a[9:0];
    logic [1:0] eresp = burst[1] ? 2'b10 : 2'b00;
    for (int b = 0; b <= len; b++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = b == wlast_at;
      if ((b == wlast_at) != (b == len)) eresp = 2'b10;
      if (!burst[1])
        for (int i = 0; i < 8; i++) if (ws[b][i]) ref_mem[int'(ba) / 8 * 8 + i] = wd[b][8*i +: 8];
      @(negedge clk); chk("wready", bus.wready, 1);
      @(posedge clk); #1;
      ba = nxt(ba, size, burst);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    @(negedge clk);
    chk("bvalid", bus.bvalid, 1);
    chk("bresp", bus.bresp, eresp);
    chk("bid", bus.bid, id);
    @(posedge clk); #1 bus.bready = 1'b0;
  endtask
  task automatic r_data(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id, input int stall_beat);
    logic [9:0] ba = a[9:0];
    logic [63:0] exp_d;
    int n;
    for (int b = 0; b <= len; b++) begin
      exp_d = burst[1] ? 64'd0 : ref_rd(ba);
      bus.rready = b != stall_beat;
      n = 0;
      @(negedge clk);
      while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
      chk("r_latency", n, 1);
      chk("rdata", bus.rdata, exp_d);
      chk("rlast", bus.rlast, b == len);
      chk("rresp", bus.rresp, burst[1] ? 2'b10 : 2'b00);
      chk("rid", bus.rid, id);
      if (b == stall_beat) begin
        repeat (5) begin
          @(negedge clk);
          chk("hold_rvalid", bus.rvalid, 1);
          chk("hold_rdata", bus.rdata, exp_d);
          chk("hold_rlast", bus.rlast, b == len);
        end
        bus.rready = 1'b1;
      end
      @(posedge clk); #1;
      ba = nxt(ba, size, burst);
    end
    bus.rready = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id, input int wlast_at);
    set_aw(a, len, size, burst, id);
    aw_wait();
    w_data(a, len, size, burst, id, wlast_at);
  endtask
  task automatic rd(input logic [31:0] a, input int len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id, input int stall_beat);
    set_ar(a, len, size, burst, id);
    ar_wait();
    r_data(a, len, size, burst, id, stall_beat);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [31:0] a;
    int len, wl, st;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] id;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rlast", bus.rlast, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_resp", {bus.bresp, bus.rresp, bus.bid, bus.rid}, 0);
    chk("rst_cen_wen", {sram_cen, sram_wen}, 2'b11);
    chk("rst_wmask", &sram_wmask, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_wdata", |sram_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    wr(32'h18, 0, 3'd3, 2'b01, 4'h3, 0);
    chk("line1_upper", sram[1][127:64], 64'h1122334455667788);
    rd(32'h18, 0, 3'd3, 2'b01, 4'h5, -1);
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    wr(32'h3F0, 3, 3'd3, 2'b01, 4'h1, 3);
    rd(32'h3F0, 3, 3'd3, 2'b01, 4'h2, -1);
    wd[0] = 64'd0; ws[0] = 8'hFF;
    wr(32'h100, 0, 3'd3, 2'b01, 4'h4, 0);
    wd[0] = '1; ws[0] = 8'h0F;
    wr(32'h100, 0, 3'd3, 2'b01, 4'h4, 0);
    chk("partial_line", sram[16][63:0], 64'h00000000FFFFFFFF);
    rd(32'h100, 0, 3'd3, 2'b01, 4'h6, -1);
    wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
    set_ar(32'h3F0, 3, 3'd3, 2'b01, 4'h2);
    set_aw(32'h200, 0, 3'd3, 2'b01, 4'h1);
    @(negedge clk);
    chk("dual1_awready", bus.awready, 1);
    chk("dual1_arready", bus.arready, 0);
    @(posedge clk); #1 bus.awvalid = 1'b0;
    w_data(32'h200, 0, 3'd3, 2'b01, 4'h1, 0);
    set_aw(32'h208, 0, 3'd3, 2'b01, 4'h7);
    @(negedge clk);
    chk("dual2_arready", bus.arready, 1);
    chk("dual2_awready", bus.awready, 0);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    r_data(32'h3F0, 3, 3'd3, 2'b01, 4'h2, 1);
    wd[0] = {$urandom, $urandom};
    aw_wait();
    w_data(32'h208, 0, 3'd3, 2'b01, 4'h7, 0);
    rd(32'h200, 1, 3'd3, 2'b01, 4'h8, -1);
    for (int b = 0; b < 4; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    wr(32'h40, 3, 3'd3, 2'b01, 4'hB, 1);
    rd(32'h40, 3, 3'd3, 2'b01, 4'hB, -1);
    for (int b = 0; b < 2; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    wr(32'h80, 1, 3'd3, 2'b10, 4'hC, 1);
    rd(32'h80, 1, 3'd3, 2'b01, 4'hC, -1);
    rd(32'h80, 0, 3'd3, 2'b10, 4'hD, -1);
    set_ar(32'h3F0, 3, 3'd3, 2'b01, 4'h9);
    ar_wait();
    bus.rready = 1'b1; n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rst_beat1_valid", bus.rvalid, 1);
    @(posedge clk); #1 bus.rready = 1'b0; n = 0;
    @(negedge clk);
    while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rst_beat2_valid", bus.rvalid, 1);
    rst = 1'b1;
    #1 chk("midrst_rvalid", bus.rvalid, 0);
    @(negedge clk); chk("midrst_rvalid_next", bus.rvalid, 0);
    @(posedge clk); #1 rst = 1'b0;
    set_ar(32'h3F0, 3, 3'd3, 2'b01, 4'hA);
    @(negedge clk); chk("postrst_arready", bus.arready, 1);
    @(posedge clk); #1 bus.arvalid = 1'b0;
    r_data(32'h3F0, 3, 3'd3, 2'b01, 4'hA, -1);
    for (int b = 0; b < 256; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
    a = $urandom;
    wr(a, 255, 3'd3, 2'b01, 4'hE, 255);
    rd(a, 255, 3'd3, 2'b01, 4'hE, 200);
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      len = $urandom_range(0, 7);
      size = 3'($urandom_range(0, 7));
      burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      id = 4'($urandom);
      wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
      st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
      for (int b = 0; b <= len; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
      wr(a, len, size, burst, id, wl);
      rd(a, len, size, burst, 4'(id + 1), st);
      if (burst[1]) rd(a, len, size, 2'b00, id, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
